// File: rtl/rgb565_row_loader.sv
// -----------------------------------------------------------------------------
// rgb565_row_loader
//
// Turns the UART receive byte stream into framebuffer writes. A row load is
// the command byte CMD_ROW, one row byte, then PIXELS_PER_ROW pixels. Each
// pixel is sent as two bytes, high byte first. Every completed pixel becomes
// one 16-bit write at {row, column}.
//
// Ports:
//   clk_in           : system clock (the only clock)
//   reset            : synchronous, active-low reset
//   rx_data          : received byte, qualified by rx_valid
//   rx_valid         : one-cycle strobe per received byte
//   ram_write_enable : one-cycle framebuffer write strobe
//   ram_addr         : {row, column} write address, held between writes
//   ram_data         : {high byte, low byte} pixel value, held between writes
//   row_done         : one-cycle pulse, coincident with the last column write
//   busy             : high while a command is in progress
//   cmd_error        : one-cycle pulse on a rejected row byte or a timeout
// -----------------------------------------------------------------------------
module rgb565_row_loader #(
  parameter logic [7:0] CMD_ROW                    = 8'h4C,
  parameter int         ROWS                       = 32,
  parameter int         ROW_ADDR_WIDTH             = 5,
  parameter int         PIXELS_PER_ROW             = 64,
  parameter int         COL_ADDR_WIDTH             = 6,
  parameter int         TIMEOUT_WIDTH              = 16,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_TICKS = 16'd4000
) (
  input  logic                                     clk_in,
  input  logic                                     reset,
  input  logic [7:0]                               rx_data,
  input  logic                                     rx_valid,
  output logic                                     ram_write_enable,
  output logic [ROW_ADDR_WIDTH+COL_ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]                              ram_data,
  output logic                                     row_done,
  output logic                                     busy,
  output logic                                     cmd_error
);

  localparam int ADDR_WIDTH    = ROW_ADDR_WIDTH + COL_ADDR_WIDTH;
  // Wide enough to hold the full payload byte count of a rejected command.
  localparam int DISCARD_WIDTH = $clog2(2 * PIXELS_PER_ROW + 1);

  localparam logic [COL_ADDR_WIDTH-1:0] LAST_COL     = COL_ADDR_WIDTH'(PIXELS_PER_ROW - 1);
  localparam logic [DISCARD_WIDTH-1:0]  DISCARD_LOAD = DISCARD_WIDTH'(2 * PIXELS_PER_ROW);
  localparam logic [TIMEOUT_WIDTH-1:0]  TIMEOUT_LAST = TIMEOUT_TICKS - TIMEOUT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_PIX_HI,
    S_PIX_LO,
    S_DISCARD
  } state_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e                     state_q,     state_d;
  logic [ROW_ADDR_WIDTH-1:0]  row_reg_q,   row_reg_d;
  logic [COL_ADDR_WIDTH-1:0]  col_q,       col_d;
  logic [7:0]                 hi_reg_q,    hi_reg_d;
  logic [DISCARD_WIDTH-1:0]   discard_q,   discard_d;
  logic [TIMEOUT_WIDTH-1:0]   timeout_q,   timeout_d;

  // Registered outputs
  logic                       ram_we_q,    ram_we_d;
  logic [ADDR_WIDTH-1:0]      ram_addr_q,  ram_addr_d;
  logic [15:0]                ram_data_q,  ram_data_d;
  logic                       row_done_q,  row_done_d;
  logic                       busy_q,      busy_d;
  logic                       cmd_error_q, cmd_error_d;

  logic                       timeout_expire;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    row_reg_d   = row_reg_q;
    col_d       = col_q;
    hi_reg_d    = hi_reg_q;
    discard_d   = discard_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    row_done_d  = 1'b0;
    cmd_error_d = 1'b0;

    // The idle counter restarts on every received byte and is parked at zero
    // while nothing is in progress. It cannot overflow: expiry returns the
    // FSM to IDLE, which clears it.
    if (rx_valid || (state_q == S_IDLE)) begin
      timeout_d = '0;
    end else begin
      timeout_d = timeout_q + TIMEOUT_WIDTH'(1);
    end

    // A byte arriving in the expiry cycle takes priority over the timeout.
    timeout_expire = (state_q != S_IDLE) && !rx_valid && (timeout_q == TIMEOUT_LAST);

    if (timeout_expire) begin
      // Any half-received pixel in hi_reg is dropped. Pixels already written
      // stay in the framebuffer.
      state_d     = S_IDLE;
      cmd_error_d = 1'b1;
    end else if (rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          // Bytes other than the command byte are line noise and are ignored.
          if (rx_data == CMD_ROW) begin
            state_d = S_ROW;
          end
        end

        S_ROW: begin
          if (int'(rx_data) < ROWS) begin
            row_reg_d = rx_data[ROW_ADDR_WIDTH-1:0];
            col_d     = '0;
            state_d   = S_PIX_HI;
          end else begin
            // Swallow the payload of the bad command so its pixel bytes are
            // never taken for a new command byte.
            cmd_error_d = 1'b1;
            discard_d   = DISCARD_LOAD;
            state_d     = S_DISCARD;
          end
        end

        // The command byte value is ordinary pixel data in both pixel states.
        S_PIX_HI: begin
          hi_reg_d = rx_data;
          state_d  = S_PIX_LO;
        end

        S_PIX_LO: begin
          ram_we_d   = 1'b1;
          ram_addr_d = {row_reg_q, col_q};
          ram_data_d = {hi_reg_q, rx_data};
          if (col_q == LAST_COL) begin
            // The last column always ends the command, so col never wraps.
            row_done_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            col_d   = col_q + COL_ADDR_WIDTH'(1);
            state_d = S_PIX_HI;
          end
        end

        S_DISCARD: begin
          discard_d = discard_q - DISCARD_WIDTH'(1);
          if (discard_q == DISCARD_WIDTH'(1)) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // busy tracks the registered state, so it falls on the same edge as the
    // final write, row_done, or the timeout error.
    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    // NOTE: reset is synchronous and active-low. It clears the partial pixel
    // and every output, so an interrupted command never produces a write.
    if (!reset) begin
      state_q     <= S_IDLE;
      row_reg_q   <= '0;
      col_q       <= '0;
      hi_reg_q    <= '0;
      discard_q   <= '0;
      timeout_q   <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      row_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep each register sampling the value
      // from before the edge, independent of statement order.
      state_q     <= state_d;
      row_reg_q   <= row_reg_d;
      col_q       <= col_d;
      hi_reg_q    <= hi_reg_d;
      discard_q   <= discard_d;
      timeout_q   <= timeout_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      row_done_q  <= row_done_d;
      busy_q      <= busy_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  assign ram_write_enable = ram_we_q;
  assign ram_addr         = ram_addr_q;
  assign ram_data         = ram_data_q;
  assign row_done         = row_done_q;
  assign busy             = busy_q;
  assign cmd_error        = cmd_error_q;

endmodule

// File: doc/rgb565_row_loader.md
# rgb565_row_loader

Parses the byte stream recovered by the controller's UART receiver into framebuffer writes. It accepts row-load commands of the form 'L' (0x4C), a row byte and PIXELS_PER_ROW big-endian RGB565 pixels. It issues one 16-bit write per pixel into the framebuffer RAM that the matrix scan logic reads. It sits between the UART RX byte output and the framebuffer write port inside `main`.

## Interface
- CMD_ROW, 8'h4C: command byte that opens a row load.
- ROWS, 32: number of valid rows; row bytes >= ROWS are rejected.
- ROW_ADDR_WIDTH, 5: row field width of the write address.
- PIXELS_PER_ROW, 64: pixels per command.
- COL_ADDR_WIDTH, 6: column field width of the write address.
- TIMEOUT_TICKS, 16'd4000: idle clocks between bytes before an in-progress command is abandoned.
- TIMEOUT_WIDTH, 16: timeout counter width.

Ports (clock and reset first):
- clk_in  input  1  system clock. This is the only clock.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk_in.
- rx_data  input  8  received byte, valid only when rx_valid is high.
- rx_valid  input  1  one-cycle strobe per received byte.
- ram_write_enable  output  1  one-cycle framebuffer write strobe.
- ram_addr  output  ROW_ADDR_WIDTH+COL_ADDR_WIDTH  {row, column} write address.
- ram_data  output  16  pixel value, {high byte, low byte}.
- row_done  output  1  one-cycle pulse, coincident with the write of the last column.
- busy  output  1  high whenever the state is not IDLE.
- cmd_error  output  1  one-cycle pulse on a rejected row byte or on a timeout.

## Operation
States and transitions:
- IDLE:
  - rx_valid with rx_data == CMD_ROW -> ROW.
  - Any other byte is ignored; the state stays IDLE and no error is raised.
- ROW:
  - Valid byte < ROWS: latch row_reg, clear col to 0, go to PIX_HI.
  - Byte >= ROWS: pulse cmd_error, load discard_cnt with 2*PIXELS_PER_ROW, go to DISCARD.
- PIX_HI: valid byte -> latch hi_reg, go to PIX_LO.
- PIX_LO: on a valid byte:
  - Register the write: ram_addr={row_reg,col}, ram_data={hi_reg,rx_data}, ram_write_enable=1.
  - If col == PIXELS_PER_ROW-1: pulse row_done, go to IDLE.
  - Otherwise: col increments, go to PIX_HI.
- DISCARD:
  - Each valid byte decrements discard_cnt.
  - When it reaches 0, go to IDLE. No writes are issued while discarding.

Timeout:
- The counter clears on every rx_valid and while in IDLE, and increments otherwise.
- In any non-IDLE state, reaching TIMEOUT_TICKS-1 forces IDLE and pulses cmd_error.
- Any partially assembled pixel is dropped; pixels already written stay written.
- If rx_valid arrives in the same cycle the counter would expire, the byte wins: it is processed normally and the counter clears.

Other rules:
- A CMD_ROW byte received while in PIX_HI or PIX_LO is treated as pixel data, not as a new command.
- Column arithmetic never wraps past PIXELS_PER_ROW-1, because the last pixel always returns the state to IDLE.
- Reset (reset==0) is allowed mid-command:
  - Next state is IDLE, col, row_reg and hi_reg are 0, and the timeout counter is 0.
  - All outputs are 0, including ram_addr and ram_data.
  - No write is emitted for a pixel that was only partially received.

## Timing
- Every output is registered.
- ram_write_enable and row_done rise on the clock edge after the rx_valid cycle of the low byte: one cycle of latency.
- ram_addr and ram_data hold their last values between writes and are stable whenever ram_write_enable is high.
- cmd_error rises on the edge after the offending row byte, or on the edge after the expiry cycle.
- busy rises on the edge after the CMD_ROW byte is received.
  - It falls on the same edge that asserts the final write or row_done, or the timeout cmd_error.
- Back-to-back rx_valid on consecutive cycles must be accepted with no bytes lost. The sustained rate is one byte per clock.
- The minimum complete command is 2+2*PIXELS_PER_ROW bytes, which is 130 with the defaults.

## Test plan
- Valid row load:
  - Stimulus: 0x4C, 0x09, 0x12, 0x34, then 126 bytes of 0x00.
  - Required: the first write has ram_addr={5'd9,6'd0} and ram_data=16'h1234.
  - Required: 64 writes in total, and row_done with the write at ram_addr={9,63}; busy then falls.
- Back-to-back commands:
  - Stimulus: row 0x18 followed immediately by row 0x19, whose first pixel is 0x5678, with rx_valid asserted every cycle.
  - Required: 128 writes, two row_done pulses, and the write at {25,0} carries 16'h5678.
- Bad row:
  - Stimulus: 0x4C, 0x20, then 128 bytes of 0xFF.
  - Required: one cmd_error pulse and zero writes.
  - Then 0x4C, 0x00, ... is accepted normally.
- Timeout:
  - Stimulus: 0x4C, 0x03, 0xAB, followed by a silence of TIMEOUT_TICKS clocks.
  - Required: cmd_error pulses, busy drops, no write occurs, and a following 0x4C command loads correctly.
- Noise and reset:
  - Stimulus: bytes 0x00, 0x41 and 0xFF while IDLE.
  - Required: no writes and no cmd_error.
  - Stimulus: assert reset==0 after 10 pixels of a command.
  - Required: all outputs read 0, and the next full command writes columns 0..63 again.
